// File: rtl/nes_pkg.sv
// ============================================================================
// Module   : nes_pkg
// Purpose  : Shared definitions for the host loader and delay_ctrl:
//            nes_op codes, host command codes and loader state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nes_pkg;

   // nes_op codes carried in writedata[15:8] towards delay_ctrl
   localparam logic [7:0] RESET_CPU = 8'd0;
   localparam logic [7:0] START_CPU = 8'd1;
   localparam logic [7:0] PAUSE_CPU = 8'd2;
   localparam logic [7:0] WRITE_MEM = 8'd3;

   // Host command bytes seen in IDLE
   localparam logic [7:0] CMD_LOAD  = 8'h01;
   localparam logic [7:0] CMD_RUN   = 8'h02;
   localparam logic [7:0] CMD_HALT  = 8'h03;
   localparam logic [7:0] CMD_PAUSE = 8'h04;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR_HI = 3'd1,
      ST_ADDR_LO = 3'd2,
      ST_LEN_HI  = 3'd3,
      ST_LEN_LO  = 3'd4,
      ST_DATA    = 3'd5,
      ST_CSUM    = 3'd6
   } loader_state_e;

   // True for host commands that translate directly into a single CPU-control write
   function automatic logic is_cpu_cmd(input logic [7:0] cmd);
      return (cmd == CMD_RUN) || (cmd == CMD_HALT) || (cmd == CMD_PAUSE);
   endfunction

   // Maps a CPU-control host command to its nes_op code
   function automatic logic [7:0] cmd_to_op(input logic [7:0] cmd);
      logic [7:0] op;
      case (cmd)
         CMD_RUN:   op = START_CPU;
         CMD_PAUSE: op = PAUSE_CPU;
         default:   op = RESET_CPU;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/nes_loader.sv
// ============================================================================
// Module   : nes_loader
// Purpose  : Parses a host byte stream (CPU-control commands and LOAD frames
//            with checksum) into registered write requests for delay_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nes_loader
   import nes_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        write,
   output logic [15:0] address,
   output logic [15:0] writedata,
   input  logic        stall,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] loaded_count
);

   loader_state_e state_q, state_d;
   logic [15:0]   addr_q, addr_d;        // next memory address of the frame
   logic [7:0]    len_hi_q, len_hi_d;
   logic [15:0]   remain_q, remain_d;    // data bytes still expected
   logic [7:0]    csum_q, csum_d;
   logic          write_q, write_d;
   logic [15:0]   address_q, address_d;
   logic [15:0]   wdata_q, wdata_d;
   logic          done_q, done_d;
   logic          pend_q, pend_d;        // command write awaiting completion before done
   logic          err_q, err_d;
   logic [15:0]   count_q, count_d;

   logic hold;
   logic accept;
   logic complete;

   assign hold     = write_q && stall;
   assign complete = write_q && !stall;
   assign in_ready = !reset && !hold;
   assign accept   = in_valid && in_ready;

   assign write        = write_q;
   assign address      = address_q;
   assign writedata    = wdata_q;
   assign done         = done_q;
   assign err          = err_q;
   assign loaded_count = count_q;
   assign busy         = (state_q != ST_IDLE) || write_q;

   // Next-state: frame parsing, write issue/hold, done and counter bookkeeping
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_hi_d  = len_hi_q;
      remain_d  = remain_q;
      csum_d    = csum_q;
      write_d   = hold;
      address_d = address_q;
      wdata_d   = wdata_q;
      done_d    = 1'b0;
      pend_d    = pend_q;
      err_d     = err_q;
      count_d   = count_q;

      if (complete) begin
         pend_d = 1'b0;
         // done for a CPU command waits until its write has actually left
         if (pend_q) done_d = 1'b1;
         if (wdata_q[15:8] == WRITE_MEM && count_q != 16'hFFFF)
            count_d = count_q + 16'd1;
      end

      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               if (in_data == CMD_LOAD) begin
                  state_d = ST_ADDR_HI;
                  count_d = 16'h0000;
                  csum_d  = 8'h00;
               end else if (is_cpu_cmd(in_data)) begin
                  write_d   = 1'b1;
                  address_d = 16'h0000;
                  wdata_d   = {cmd_to_op(in_data), 8'h00};
                  pend_d    = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            ST_ADDR_HI: begin
               addr_d[15:8] = in_data;
               state_d      = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
               addr_d[7:0] = in_data;
               state_d     = ST_LEN_HI;
            end
            ST_LEN_HI: begin
               len_hi_d = in_data;
               state_d  = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               remain_d = {len_hi_q, in_data};
               state_d  = ({len_hi_q, in_data} == 16'h0000) ? ST_CSUM : ST_DATA;
            end
            ST_DATA: begin
               write_d   = 1'b1;
               address_d = addr_q;
               wdata_d   = {WRITE_MEM, in_data};
               addr_d    = addr_q + 16'd1;
               csum_d    = csum_q ^ in_data;
               remain_d  = remain_q - 16'd1;
               if (remain_q == 16'd1) state_d = ST_CSUM;
            end
            ST_CSUM: begin
               // accepting this byte implies every data write has completed
               if (in_data != csum_q) err_d = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= 16'h0000;
         len_hi_q  <= 8'h00;
         remain_q  <= 16'h0000;
         csum_q    <= 8'h00;
         write_q   <= 1'b0;
         address_q <= 16'h0000;
         wdata_q   <= 16'h0000;
         done_q    <= 1'b0;
         pend_q    <= 1'b0;
         err_q     <= 1'b0;
         count_q   <= 16'h0000;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_hi_q  <= len_hi_d;
         remain_q  <= remain_d;
         csum_q    <= csum_d;
         write_q   <= write_d;
         address_q <= address_d;
         wdata_q   <= wdata_d;
         done_q    <= done_d;
         pend_q    <= pend_d;
         err_q     <= err_d;
         count_q   <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_nes_loader.sv
// ============================================================================
// Module   : tb_nes_loader
// Purpose  : Self-checking bench for nes_loader: directed frames plus a
//            randomized command/LOAD mix with random downstream stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nes_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        write;
   logic [15:0] address;
   logic [15:0] writedata;
   logic        stall = 1'b0;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] loaded_count;

   nes_loader dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .write        (write),
      .address      (address),
      .writedata    (writedata),
      .stall        (stall),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .loaded_count (loaded_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model state: expected completed writes {address, writedata}
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   int          exp_done = 0;
   int          done_cnt = 0;
   logic        exp_err = 1'b0;
   logic [15:0] exp_lc = 16'h0000;
   logic [7:0]  dbuf[0:63];
   int          last_wait = 0;

   // Downstream stall generator: forced runs or random
   int stall_hold = 0;
   bit rnd_stall = 1'b0;
   initial forever begin
      @(negedge clk);
      if (stall_hold > 0) begin
         stall = 1'b1;
         stall_hold--;
      end else begin
         stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
   end

   // Write/done monitor; also checks that stalled writes hold still
   bit          prev_hold = 1'b0;
   logic [15:0] prev_a, prev_wd;
   initial forever begin
      @(negedge clk);
      #2;
      if (reset) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_write", {31'd0, write}, 32'd1);
            chk("hold_address", {16'd0, address}, {16'd0, prev_a});
            chk("hold_writedata", {16'd0, writedata}, {16'd0, prev_wd});
         end
         if (write && !stall) obs_q.push_back({address, writedata});
         if (done) done_cnt++;
         prev_hold = write && stall;
         prev_a    = address;
         prev_wd   = writedata;
      end
   end

   task automatic send(input logic [7:0] b);
      int w = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      #1;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk("accept_within_bound", {31'd0, (w < 50)}, 32'd1);
      @(posedge clk);
      last_wait = w;
      #1;
      in_valid = 1'b0;
   endtask

   task automatic cmd(input logic [7:0] b);
      send(b);
      case (b)
         8'h02: begin exp_q.push_back(32'h0000_0100); exp_done++; end
         8'h03: begin exp_q.push_back(32'h0000_0000); exp_done++; end
         8'h04: begin exp_q.push_back(32'h0000_0200); exp_done++; end
         default: exp_err = 1'b1;
      endcase
   endtask

   task automatic load_frame(input logic [15:0] a, input int len, input bit good, input logic [7:0] bad);
      logic [7:0]  x = 8'h00;
      logic [7:0]  cs;
      logic [15:0] l16 = 16'(len);
      for (int i = 0; i < len; i++) x ^= dbuf[i];
      cs = good ? x : ((bad == x) ? (bad ^ 8'h01) : bad);
      send(8'h01);
      send(a[15:8]);
      send(a[7:0]);
      send(l16[15:8]);
      send(l16[7:0]);
      for (int i = 0; i < len; i++) send(dbuf[i]);
      send(cs);
      for (int i = 0; i < len; i++) exp_q.push_back({a + 16'(i), 8'h03, dbuf[i]});
      exp_lc = l16;
      if (cs != x) exp_err = 1'b1;
      exp_done++;
   endtask

   task automatic drain_check(input string tag);
      int idle = 0;
      int n = 0;
      int m;
      while (idle < 3 && n < 200) begin
         @(negedge clk);
         #3;
         n++;
         if (!write && stall_hold == 0) idle++;
         else idle = 0;
      end
      chk({tag, "_drain_bound"}, {31'd0, (n < 200)}, 32'd1);
      chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) chk({tag, "_write"}, obs_q[i], exp_q[i]);
      chk({tag, "_done_pulses"}, done_cnt, exp_done);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      chk({tag, "_loaded_count"}, {16'd0, loaded_count}, {16'd0, exp_lc});
      chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
      obs_q.delete();
      exp_q.delete();
      done_cnt = 0;
      exp_done = 0;
   endtask

   initial begin
      // Reset values and in_ready behaviour around reset
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_write", {31'd0, write}, 32'd0);
      chk("rst_address", {16'd0, address}, 32'd0);
      chk("rst_writedata", {16'd0, writedata}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_loaded_count", {16'd0, loaded_count}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Basic LOAD with good checksum
      dbuf[0] = 8'hAA; dbuf[1] = 8'hBB; dbuf[2] = 8'hCC;
      load_frame(16'h8000, 3, 1'b1, 8'h00);
      drain_check("load_ok");

      // Same frame with bad checksum: writes still happen, err set
      load_frame(16'h8000, 3, 1'b0, 8'h00);
      drain_check("load_badcsum");

      // Address wrap at 0xFFFF
      dbuf[0] = 8'h11; dbuf[1] = 8'h22;
      load_frame(16'hFFFF, 2, 1'b1, 8'h00);
      drain_check("load_wrap");

      // Stall for 5 cycles on the second data write
      dbuf[0] = 8'hAA; dbuf[1] = 8'hBB; dbuf[2] = 8'hCC;
      send(8'h01);
      chk("busy_in_frame", {31'd0, busy}, 32'd1);
      send(8'h80); send(8'h00); send(8'h00); send(8'h03);
      send(8'hAA); send(8'hBB);
      stall_hold = 5;
      send(8'hCC);
      chk("stall_in_ready_low_cycles", last_wait, 32'd5);
      send(8'hDD);
      exp_q.push_back(32'h8000_03AA);
      exp_q.push_back(32'h8001_03BB);
      exp_q.push_back(32'h8002_03CC);
      exp_lc = 16'd3;
      exp_done++;
      drain_check("load_stall");

      // CPU-control commands and an illegal command byte
      cmd(8'h02);
      cmd(8'h03);
      cmd(8'h7F);
      drain_check("commands");

      // Reset mid-frame abandons it; next byte is a command
      send(8'h01); send(8'h12); send(8'h34); send(8'h00); send(8'h04);
      send(8'h5A);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      #1;
      chk("midrst_write", {31'd0, write}, 32'd0);
      chk("midrst_address", {16'd0, address}, 32'd0);
      chk("midrst_writedata", {16'd0, writedata}, 32'd0);
      chk("midrst_err", {31'd0, err}, 32'd0);
      chk("midrst_loaded_count", {16'd0, loaded_count}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_no_write", obs_q.size(), 32'd0);
      exp_err = 1'b0;
      exp_lc  = 16'h0000;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
      cmd(8'h04);
      drain_check("after_midrst");

      // Randomized mix of commands and LOAD frames under random stall
      rnd_stall = 1'b1;
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if (b == 8'h01) b = 8'h02;
            cmd(b);
         end else begin
            logic [15:0] a;
            int          len;
            a   = ($urandom_range(0, 2) == 0) ? (16'hFFFF - 16'($urandom_range(0, 3)))
                                              : 16'($urandom);
            len = $urandom_range(0, 8);
            for (int i = 0; i < len; i++) dbuf[i] = 8'($urandom);
            load_frame(a, len, ($urandom_range(0, 3) != 0), 8'($urandom));
         end
         if (it % 3 == 2) drain_check("random");
      end
      drain_check("random_final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nes_loader.md
NES_LOADER -- requirements
Module: nes_loader

Interface
REQ-001 clk  in  1  sole clock; all state changes on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 in_data  in  8  host byte-stream data.
REQ-004 in_valid  in  1  in_data valid.
REQ-005 in_ready  out  1  loader accepts byte; transfer when in_valid && in_ready.
REQ-006 write  out  1  write strobe to the delay_ctrl slave port.
REQ-007 address  out  16  target memory address.
REQ-008 writedata  out  16  {nes_op[7:0], data[7:0]} to delay_ctrl.
REQ-009 stall  in  1  downstream not ready; a write completes on the cycle write && !stall.
REQ-010 busy  out  1  high in any state other than IDLE, or while write is high.
REQ-011 done  out  1  one-cycle pulse when a frame completes.
REQ-012 err  out  1  sticky error flag.
REQ-013 loaded_count  out  16  data writes completed in the current or last LOAD.

Function
REQ-014 Host command bytes: 0x01 LOAD; 0x02 RUN->START_CPU; 0x03 HALT->RESET_CPU; 0x04 PAUSE->PAUSE_CPU.
REQ-015 States: IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA, CSUM.
REQ-016 LOAD frame, in order: 0x01, addr_hi, addr_lo, len_hi, len_lo, len data bytes, checksum byte.
REQ-017 IDLE: a command byte of 0x01 moves the FSM to ADDR_HI; 0x02-0x04 issue one write of {op,8'h00} to address 0x0000, raise done, and keep the FSM in IDLE; any other value sets err, the byte is consumed, and the FSM stays in IDLE.
REQ-018 LOAD header state transitions: ADDR_HI->ADDR_LO->LEN_HI->LEN_LO.
REQ-019 On the LEN_LO byte: a length of 0 moves the FSM to CSUM; any other length moves it to DATA.
REQ-020 On entering ADDR_HI: clear loaded_count and the running checksum.
REQ-021 DATA: each accepted byte b produces a write of {WRITE_MEM, b} at the current address on the next cycle, then increments the address and XORs b into the checksum.
REQ-022 Address arithmetic is 16-bit modulo: 0xFFFF + 1 = 0x0000.
REQ-023 DATA exits to CSUM after the len-th byte is accepted.
REQ-024 CSUM: compare the accepted byte with the XOR of all data bytes; on mismatch set err (writes already issued are not undone); pulse done; return to IDLE.
REQ-025 write, address and writedata are registered; latency from byte accept to write high is 1 cycle.
REQ-026 While write && stall: write, address and writedata hold stable and in_ready = 0.
REQ-027 Otherwise in_ready = 1 in every state.
REQ-028 Throughput: 1 byte per cycle when stall = 0.
REQ-029 write deasserts the cycle after completion unless a new byte was accepted on the completion cycle.
REQ-030 loaded_count increments on each completed WRITE_MEM write and saturates at 0xFFFF.
REQ-031 A done pulse for a frame fires no earlier than the completion of that frame's last write.
REQ-032 err clears only on reset.

Reset
REQ-033 reset forces state = IDLE; write = 0, address = 0x0000, writedata = 0x0000, done = 0, err = 0, loaded_count = 0, checksum = 0.
REQ-034 reset mid-frame or mid-stall abandons the frame; no further write is issued.
REQ-035 in_ready = 0 during reset.
REQ-036 in_ready = 1 on the first cycle after reset deasserts.

Structure
REQ-037 Package nes_pkg holds the nes_op constants RESET_CPU = 8'd0, START_CPU = 8'd1, PAUSE_CPU = 8'd2, WRITE_MEM = 8'd3; delay_ctrl uses the same package.
REQ-038 nes_pkg also holds the host command codes and the loader state enum.
REQ-039 nes_loader is a single module with no sub-module; it is instantiated directly upstream of delay_ctrl.

Verification
REQ-040 LOAD addr 0x8000, len 3, data AA BB CC, checksum 0xDD, stall = 0 -> writes 0x03AA@8000, 0x03BB@8001, 0x03CC@8002; loaded_count = 3; done pulses once; err = 0.
REQ-041 Same frame with checksum 0x00 -> the three writes still occur; err = 1 after the CSUM byte and stays 1.
REQ-042 LOAD addr 0xFFFF, len 2, data 11 22, checksum 0x33 -> writes at 0xFFFF and 0x0000.
REQ-043 stall held high 5 cycles during the second data write -> write, address and writedata stable; in_ready = 0 for those 5 cycles; no byte lost or duplicated.
REQ-044 Byte 0x02, then 0x03, then 0x7F -> writes 0x0100@0000 and 0x0000@0000, two done pulses; 0x7F sets err and produces no write.
REQ-045 reset asserted after the first data byte of a len-4 LOAD -> all outputs at reset values; the next byte is parsed as a command.
